// File: rtl/hazard_pkg.sv
// hazard_pkg
// Shared definitions for the pipeline hazard controller: the data-memory
// wait FSM state encoding and the default data-memory timeout budget.
package hazard_pkg;

   // Default number of data-memory wait cycles tolerated before timeout.
   localparam int unsigned MAX_WAIT_DEFAULT = 255;

   // RUN: no data-memory access outstanding. DWAIT: pipeline frozen on MEM.
   typedef enum logic [0:0] {
      RUN   = 1'b0,
      DWAIT = 1'b1
   } fsm_state_e;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
// Saturating up-counter used for the hazard performance counters.
// Ports:
//   clk      - clock, rising edge
//   clr      - synchronous clear, highest priority
//   load     - synchronous load of load_val (below clr)
//   load_val - value taken on load
//   inc      - increment enable; holds at all-ones instead of wrapping
//   cnt      - registered count
module sat_counter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             inc,
   output logic [WIDTH-1:0] cnt
);

   localparam logic [WIDTH-1:0] CNT_MAX = '1;
   localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] cnt_d;
   logic [WIDTH-1:0] cnt_q;

   // Next count: load, then saturating increment.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (inc && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_ONE;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register with synchronous clear.
   always_ff @(posedge clk) begin
      if (clr) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Pipeline hazard controller for a 5-stage in-order core. Produces the
// stall/flush controls (combinational, fixed priority: memory wait, taken
// branch, load-use, fetch wait), tracks data-memory waits with a RUN/DWAIT
// FSM and a sticky timeout flag, and keeps stall/flush performance counters.
// Ports:
//   clk, reset                     - clock, synchronous active-high reset
//   rs_d, rt_d, uses_rs_d/rt_d     - ID-stage sources and their valid bits
//   memread_e, rt_e                - EX-stage load and its destination
//   branch_taken_e                 - PC redirect resolved in EX
//   dmem_req, dmem_ready           - MEM-stage access pending / completing
//   imem_ready                     - fetch data valid
//   stall_f/d/e/m, flush_d/e       - pipeline register controls
//   stall_cnt, flush_cnt           - saturating performance counters
//   mem_timeout                    - sticky data-memory timeout error
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  rs_d,
   input  logic [4:0]  rt_d,
   input  logic        uses_rs_d,
   input  logic        uses_rt_d,
   input  logic        memread_e,
   input  logic [4:0]  rt_e,
   input  logic        branch_taken_e,
   input  logic        dmem_req,
   input  logic        dmem_ready,
   input  logic        imem_ready,
   output logic        stall_f,
   output logic        stall_d,
   output logic        stall_e,
   output logic        stall_m,
   output logic        flush_d,
   output logic        flush_e,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt,
   output logic        mem_timeout
);

   localparam int unsigned WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
   localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

   logic mem_wait_s;
   logic load_use_s;

   fsm_state_e        state_d,       state_q;
   logic [WAIT_W-1:0] wait_cnt_d,    wait_cnt_q;
   logic              mem_timeout_d, mem_timeout_q;

   assign mem_wait_s = dmem_req && !dmem_ready;
   assign load_use_s = memread_e && (rt_e != 5'd0) &&
                       ((uses_rs_d && (rs_d == rt_e)) ||
                        (uses_rt_d && (rt_d == rt_e)));

   // Stall/flush controls; a branch seen during a memory wait is simply
   // not acted on until the wait ends, because EX is frozen.
   always_comb begin
      stall_f = 1'b0;
      stall_d = 1'b0;
      stall_e = 1'b0;
      stall_m = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      if (mem_wait_s) begin
         stall_f = 1'b1;
         stall_d = 1'b1;
         stall_e = 1'b1;
         stall_m = 1'b1;
      end else if (branch_taken_e) begin
         flush_d = 1'b1;
         flush_e = 1'b1;
      end else if (load_use_s) begin
         stall_f = 1'b1;
         stall_d = 1'b1;
         flush_e = 1'b1;
      end else if (!imem_ready) begin
         stall_f = 1'b1;
         flush_d = 1'b1;
      end else begin
         stall_f = 1'b0;
      end
   end

   // Data-memory wait FSM, wait counter and sticky timeout next state.
   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      mem_timeout_d = mem_timeout_q;
      case (state_q)
         RUN: begin
            wait_cnt_d = '0;
            if (mem_wait_s) begin
               state_d = DWAIT;
            end else begin
               state_d = RUN;
            end
         end
         DWAIT: begin
            if (dmem_ready) begin
               state_d = RUN;
            end else begin
               // Timeout does not force an exit; the counter parks at the
               // last value so it never wraps back below the threshold.
               if (wait_cnt_q == WAIT_LAST) begin
                  mem_timeout_d = 1'b1;
               end else begin
                  wait_cnt_d = wait_cnt_q + WAIT_ONE;
               end
            end
         end
         default: begin
            state_d    = RUN;
            wait_cnt_d = '0;
         end
      endcase
   end

   // FSM, wait counter and timeout registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= RUN;
         wait_cnt_q    <= '0;
         mem_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         mem_timeout_q <= mem_timeout_d;
      end
   end

   assign mem_timeout = mem_timeout_q;

   sat_counter #(.WIDTH(32)) u_stall_cnt (
      .clk      (clk),
      .clr      (reset),
      .load     (1'b0),
      .load_val (32'h0000_0000),
      .inc      (stall_d),
      .cnt      (stall_cnt)
   );

   // Only taken-branch flushes are counted, not load-use bubbles.
   sat_counter #(.WIDTH(32)) u_flush_cnt (
      .clk      (clk),
      .clr      (reset),
      .load     (1'b0),
      .load_val (32'h0000_0000),
      .inc      (branch_taken_e && flush_e),
      .cnt      (flush_cnt)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
// Directed, table-driven bench for hazard_ctrl (MAX_WAIT=4) plus a
// standalone sat_counter instance for the saturation boundary.
module tb_hazard_ctrl;
   import hazard_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  rs_d, rt_d, rt_e;
   logic        uses_rs_d, uses_rt_d, memread_e, branch_taken_e;
   logic        dmem_req, dmem_ready, imem_ready;
   logic        stall_f, stall_d, stall_e, stall_m, flush_d, flush_e;
   logic [31:0] stall_cnt, flush_cnt;
   logic        mem_timeout;

   logic        sat_clr, sat_load, sat_inc;
   logic [31:0] sat_val, sat_cnt;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_stall = 32'd0;
   logic [31:0] exp_flush = 32'd0;

   always #5 clk = ~clk;

   hazard_ctrl #(.MAX_WAIT(4)) dut (
      .clk(clk), .reset(reset),
      .rs_d(rs_d), .rt_d(rt_d), .uses_rs_d(uses_rs_d), .uses_rt_d(uses_rt_d),
      .memread_e(memread_e), .rt_e(rt_e), .branch_taken_e(branch_taken_e),
      .dmem_req(dmem_req), .dmem_ready(dmem_ready), .imem_ready(imem_ready),
      .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
      .flush_d(flush_d), .flush_e(flush_e),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_timeout(mem_timeout)
   );

   sat_counter #(.WIDTH(32)) u_sat (
      .clk(clk), .clr(sat_clr), .load(sat_load), .load_val(sat_val),
      .inc(sat_inc), .cnt(sat_cnt)
   );

   // inputs, then expected {stall_f,stall_d,stall_e,stall_m,flush_d,flush_e}
   typedef struct {
      logic [4:0] rs; logic [4:0] rt; logic urs; logic urt; logic mr;
      logic [4:0] rte; logic br; logic dreq; logic drdy; logic irdy;
      logic [5:0] exp; logic sinc; logic finc;
   } vec_t;

   vec_t vecs [14];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic idle();
      rs_d = 5'd0; rt_d = 5'd0; uses_rs_d = 1'b0; uses_rt_d = 1'b0;
      memread_e = 1'b0; rt_e = 5'd0; branch_taken_e = 1'b0;
      dmem_req = 1'b0; dmem_ready = 1'b1; imem_ready = 1'b1;
   endtask

   // Check outputs for the current inputs, clock once, check counters.
   task automatic step(input string nm, input logic [5:0] exp_out,
                       input logic sinc, input logic finc);
      #1;
      chk({nm, "_ctl"}, {26'd0, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e},
          {26'd0, exp_out});
      @(posedge clk);
      if (sinc && exp_stall != 32'hFFFF_FFFF) exp_stall = exp_stall + 32'd1;
      if (finc && exp_flush != 32'hFFFF_FFFF) exp_flush = exp_flush + 32'd1;
      #1;
      chk({nm, "_scnt"}, stall_cnt, exp_stall);
      chk({nm, "_fcnt"}, flush_cnt, exp_flush);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      //          rs     rt     urs   urt   mr    rte    br    dreq  drdy  irdy  exp        sinc  finc
      vecs[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 6'b000000, 1'b0, 1'b0};
      vecs[1]  = '{5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1, 1'b1, 6'b110001, 1'b1, 1'b0};
      vecs[2]  = '{5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 6'b000000, 1'b0, 1'b0};
      vecs[3]  = '{5'd1, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1, 6'b110001, 1'b1, 1'b0};
      vecs[4]  = '{5'd1, 5'd5, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1, 6'b000000, 1'b0, 1'b0};
      vecs[5]  = '{5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0, 1'b1, 1'b1, 6'b000000, 1'b0, 1'b0};
      vecs[6]  = '{5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, 6'b000011, 1'b0, 1'b1};
      vecs[7]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 6'b000011, 1'b0, 1'b1};
      vecs[8]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b100010, 1'b0, 1'b0};
      vecs[9]  = '{5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 6'b110001, 1'b1, 1'b0};
      vecs[10] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 6'b000011, 1'b0, 1'b1};
      vecs[11] = '{5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 6'b111100, 1'b1, 1'b0};
      vecs[12] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 6'b000011, 1'b0, 1'b1};
      vecs[13] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 6'b000000, 1'b0, 1'b0};

      idle();
      reset = 1'b1;
      sat_clr = 1'b1; sat_load = 1'b0; sat_inc = 1'b0; sat_val = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_scnt", stall_cnt, 32'd0);
      chk("rst_fcnt", flush_cnt, 32'd0);
      chk("rst_tmo", {31'd0, mem_timeout}, 32'd0);
      chk("rst_state", 32'(dut.state_q), 32'(RUN));
      reset = 1'b0;
      sat_clr = 1'b0;

      // table-driven single-cycle vectors
      for (int i = 0; i < 14; i++) begin
         rs_d = vecs[i].rs; rt_d = vecs[i].rt;
         uses_rs_d = vecs[i].urs; uses_rt_d = vecs[i].urt;
         memread_e = vecs[i].mr; rt_e = vecs[i].rte;
         branch_taken_e = vecs[i].br; dmem_req = vecs[i].dreq;
         dmem_ready = vecs[i].drdy; imem_ready = vecs[i].irdy;
         step($sformatf("vec%0d", i), vecs[i].exp, vecs[i].sinc, vecs[i].finc);
      end
      chk("vec_state", 32'(dut.state_q), 32'(RUN));

      // memory wait: three stalled cycles then completion
      idle();
      dmem_req = 1'b1; dmem_ready = 1'b0;
      step("mw1", 6'b111100, 1'b1, 1'b0);
      chk("mw1_state", 32'(dut.state_q), 32'(DWAIT));
      step("mw2", 6'b111100, 1'b1, 1'b0);
      step("mw3", 6'b111100, 1'b1, 1'b0);
      chk("mw3_state", 32'(dut.state_q), 32'(DWAIT));
      dmem_ready = 1'b1;
      step("mw_done", 6'b000000, 1'b0, 1'b0);
      chk("mw_done_state", 32'(dut.state_q), 32'(RUN));
      chk("mw_tmo", {31'd0, mem_timeout}, 32'd0);

      // branch held during a wait takes effect when the wait ends
      dmem_ready = 1'b0; branch_taken_e = 1'b1;
      step("db1", 6'b111100, 1'b1, 1'b0);
      step("db2", 6'b111100, 1'b1, 1'b0);
      dmem_ready = 1'b1;
      step("db_go", 6'b000011, 1'b0, 1'b1);
      chk("db_state", 32'(dut.state_q), 32'(RUN));

      // timeout after the fourth DWAIT cycle, sticky past completion
      idle();
      dmem_req = 1'b1; dmem_ready = 1'b0;
      for (int i = 0; i < 4; i++) step($sformatf("to%0d", i), 6'b111100, 1'b1, 1'b0);
      chk("to_before", {31'd0, mem_timeout}, 32'd0);
      step("to4", 6'b111100, 1'b1, 1'b0);
      chk("to_rise", {31'd0, mem_timeout}, 32'd1);
      chk("to_state", 32'(dut.state_q), 32'(DWAIT));
      idle();
      step("to_done", 6'b000000, 1'b0, 1'b0);
      chk("to_sticky1", {31'd0, mem_timeout}, 32'd1);
      chk("to_done_state", 32'(dut.state_q), 32'(RUN));
      step("to_idle", 6'b000000, 1'b0, 1'b0);
      chk("to_sticky2", {31'd0, mem_timeout}, 32'd1);

      // reset in the middle of a wait
      dmem_req = 1'b1; dmem_ready = 1'b0;
      step("rw1", 6'b111100, 1'b1, 1'b0);
      step("rw2", 6'b111100, 1'b1, 1'b0);
      chk("rw_state", 32'(dut.state_q), 32'(DWAIT));
      reset = 1'b1;
      @(posedge clk);
      #1;
      exp_stall = 32'd0;
      exp_flush = 32'd0;
      chk("rw_rst_state", 32'(dut.state_q), 32'(RUN));
      chk("rw_rst_scnt", stall_cnt, 32'd0);
      chk("rw_rst_fcnt", flush_cnt, 32'd0);
      chk("rw_rst_tmo", {31'd0, mem_timeout}, 32'd0);
      reset = 1'b0;
      idle();
      step("rw_after", 6'b000000, 1'b0, 1'b0);

      // saturation boundary on a preloaded counter
      sat_load = 1'b1; sat_val = 32'hFFFF_FFFE;
      @(posedge clk); #1;
      chk("sat_load", sat_cnt, 32'hFFFF_FFFE);
      sat_load = 1'b0; sat_inc = 1'b1;
      @(posedge clk); #1;
      chk("sat_top", sat_cnt, 32'hFFFF_FFFF);
      @(posedge clk); #1;
      chk("sat_hold1", sat_cnt, 32'hFFFF_FFFF);
      @(posedge clk); #1;
      chk("sat_hold2", sat_cnt, 32'hFFFF_FFFF);
      sat_clr = 1'b1;
      @(posedge clk); #1;
      chk("sat_clr", sat_cnt, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 255, meaning the data-memory wait cycles before timeout is flagged.
REQ-002 SHALL have ports clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have ports reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have ports rs_d / rt_d, input, 5 each, the ID-stage source registers; uses_rs_d / uses_rt_d, input, 1 each, source-valid qualifiers.
REQ-005 SHALL have ports memread_e, input, 1, EX-stage instruction is a load; rt_e, input, 5, its destination register.
REQ-006 SHALL have port branch_taken_e, input, 1, branch/jump resolved taken in EX (PC redirect this cycle).
REQ-007 SHALL have ports dmem_req, input, 1, MEM-stage access pending; dmem_ready, input, 1, access completes this cycle; imem_ready, input, 1, fetch data valid this cycle.
REQ-008 SHALL have outputs stall_f, stall_d, stall_e, stall_m, each 1 bit, holding PC, IF/ID, ID/EX and EX/MEM respectively.
REQ-009 SHALL have outputs flush_d and flush_e, each 1 bit, loading a bubble into IF/ID and ID/EX respectively.
REQ-010 SHALL have outputs stall_cnt and flush_cnt, each 32 bits, performance counters; mem_timeout, 1 bit, sticky error.

Function
REQ-011 SHALL compute stall/flush outputs combinationally from inputs using the strict priority of REQ-012..016 (first match wins).
REQ-012 SHALL, on memory wait (dmem_req=1, dmem_ready=0), drive stall_f=stall_d=stall_e=stall_m=1 and flush_d=flush_e=0, regardless of all other inputs.
REQ-013 SHALL, on branch_taken_e=1, drive stall_f=0, stall_d=0, flush_d=1, flush_e=1; this overrides load-use and fetch-wait.
REQ-014 SHALL detect load-use as memread_e=1 AND rt_e!=0 AND ((uses_rs_d AND rs_d==rt_e) OR (uses_rt_d AND rt_d==rt_e)); drive stall_f=1, stall_d=1, flush_e=1, flush_d=0.
REQ-015 SHALL, on imem_ready=0, drive stall_f=1, flush_d=1, all others 0.
REQ-016 SHALL otherwise drive all stall/flush outputs 0.
REQ-017 SHALL implement FSM states RUN and DWAIT: RUN->DWAIT when dmem_req=1 and dmem_ready=0; DWAIT->RUN when dmem_ready=1; DWAIT stays otherwise.
REQ-018 SHALL keep a wait counter that is cleared in RUN and increments once per DWAIT cycle in which dmem_ready=0.
REQ-019 SHALL set mem_timeout on the edge where the wait counter equals MAX_WAIT-1 with dmem_ready=0; mem_timeout stays set until reset; FSM remains in DWAIT (no forced exit).
REQ-020 SHALL increment stall_cnt on each cycle with stall_d=1, and increment flush_cnt on each cycle with branch_taken_e=1 and flush_e=1.
REQ-021 SHALL saturate both counters at 32'hFFFF_FFFF (no wrap).
REQ-022 SHALL give dmem_ready=1 in the same cycle as dmem_req=1 no stall (zero-wait access).
REQ-023 SHALL treat a branch held during a memory wait as deferred: it takes effect (REQ-013) in the cycle dmem_ready=1, since EX is frozen.

Reset
REQ-024 SHALL, on reset=1 at a clk edge, set FSM=RUN, wait counter=0, stall_cnt=0, flush_cnt=0, mem_timeout=0; reset mid-DWAIT aborts the wait.
REQ-025 SHALL give reset priority over every other update in the same cycle.

Structure
REQ-026 SHALL take the FSM state enum and the MAX_WAIT default from shared package hazard_pkg.
REQ-027 SHALL implement each performance counter as an instance of sub-module sat_counter (32-bit, synchronous clear, increment enable, saturating).

Verification
REQ-028 SHALL verify load-use: memread_e=1, rt_e=8, uses_rs_d=1, rs_d=8 -> stall_f=stall_d=flush_e=1 for 1 cycle, stall_cnt +1; with rt_e=0 -> no stall.
REQ-029 SHALL verify branch vs load-use: branch_taken_e=1 with load-use hit -> flush_d=flush_e=1, stall_f=stall_d=0, flush_cnt +1.
REQ-030 SHALL verify memory wait: dmem_req=1, dmem_ready=0 for 3 cycles, then 1 -> all four stalls=1 for 3 cycles, FSM DWAIT then RUN, stall_cnt +3.
REQ-031 SHALL verify timeout: MAX_WAIT=4, dmem_ready=0 held -> mem_timeout rises after 4th wait cycle and stays 1 after dmem_ready=1 until reset.
REQ-032 SHALL verify fetch wait and reset: imem_ready=0 -> stall_f=flush_d=1 only; preload counters to 32'hFFFF_FFFF -> stays saturated; reset asserted in DWAIT -> RUN, all counters 0 next cycle.
